// File: rtl/jbi_sched_pkg.sv
// Shared definitions for the JBI-to-SCTAG request scheduler.
//   state_t       : scheduler FSM encoding
//   *_BEATS_DEF   : default packet lengths in 32-bit beats
//   *_CRED_W      : credit counter widths, BCNT_W beat counter width
package jbi_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RD_XFER = 2'b01,
    WR_XFER = 2'b10
  } state_t;

  localparam int unsigned RD_BEATS_DEF = 2;
  localparam int unsigned WR_BEATS_DEF = 18;
  localparam int unsigned IQ_CRED_W    = 5;
  localparam int unsigned WIB_CRED_W   = 3;
  localparam int unsigned BCNT_W       = 5;

endpackage

// File: rtl/jbi_cred_cnt.sv
// Saturating credit counter.
//   clk, rst_n : clock, async active-low reset (count resets to MAX)
//   take       : one credit consumed this cycle
//   deq        : one credit returned this cycle
//   cnt        : current credit count
//   err        : sticky overflow (return while already at MAX)
module jbi_cred_cnt #(
  parameter int unsigned MAX = 16,
  parameter int unsigned W   = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         take,
  input  logic         deq,
  output logic [W-1:0] cnt,
  output logic         err
);

  // Take and return in the same cycle cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= W'(MAX);
      err <= 1'b0;
    end else begin
      case ({take, deq})
        2'b10: cnt <= cnt - W'(1);
        2'b01: begin
          if (cnt == W'(MAX)) err <= 1'b1;
          else                cnt <= cnt + W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/jbi_sctag_req_sched.sv
// Round-robin scheduler serialising read/write request packets onto the
// 32-bit JBI-to-SCTAG request bus, gated by IQ/WIB credits and POR.
//   rclk, arst_l               : clock, async active-low reset
//   rd_req/rd_data             : read source request and current beat
//   rd_beat_rdy/rd_beat_idx    : read beat consumed / index being driven
//   wr_req/wr_data             : write source request and current beat
//   wr_beat_rdy/wr_beat_idx    : write beat consumed / index being driven
//   sctag_jbi_iq_dequeue       : IQ credit return pulse
//   sctag_jbi_wib_dequeue      : WIB credit return pulse
//   sctag_jbi_por_req          : blocks new grants
//   jbi_sctag_req(_vld)        : bus beat, valid on beat 0 only
//   iq_cred, wib_cred, cred_err: credit counts, sticky overflow
module jbi_sctag_req_sched
  import jbi_sched_pkg::*;
#(
  parameter int unsigned IQ_CREDITS  = 16,
  parameter int unsigned WIB_CREDITS = 4,
  parameter int unsigned RD_BEATS    = RD_BEATS_DEF,
  parameter int unsigned WR_BEATS    = WR_BEATS_DEF
) (
  input  logic        rclk,
  input  logic        arst_l,
  input  logic        rd_req,
  input  logic [31:0] rd_data,
  output logic        rd_beat_rdy,
  output logic [4:0]  rd_beat_idx,
  input  logic        wr_req,
  input  logic [31:0] wr_data,
  output logic        wr_beat_rdy,
  output logic [4:0]  wr_beat_idx,
  input  logic        sctag_jbi_iq_dequeue,
  input  logic        sctag_jbi_wib_dequeue,
  input  logic        sctag_jbi_por_req,
  output logic [31:0] jbi_sctag_req,
  output logic        jbi_sctag_req_vld,
  output logic [4:0]  iq_cred,
  output logic [2:0]  wib_cred,
  output logic        cred_err
);

  state_t              state;
  logic [BCNT_W-1:0]   bcnt;
  logic                rr_rd;
  logic                arb_pt;
  logic                rd_elig;
  logic                wr_elig;
  logic                grant_rd;
  logic                grant_wr;
  logic                iq_err;
  logic                wib_err;

  // Arbitration happens in IDLE and on the last beat of a packet.
  always_comb begin
    arb_pt   = 1'b0;
    rd_elig  = 1'b0;
    wr_elig  = 1'b0;
    grant_rd = 1'b0;
    grant_wr = 1'b0;
    case (state)
      IDLE:    arb_pt = 1'b1;
      RD_XFER: arb_pt = (bcnt == BCNT_W'(RD_BEATS - 1));
      WR_XFER: arb_pt = (bcnt == BCNT_W'(WR_BEATS - 1));
      default: arb_pt = 1'b1;
    endcase
    rd_elig  = rd_req && (iq_cred != '0) && !sctag_jbi_por_req;
    wr_elig  = wr_req && (iq_cred != '0) && (wib_cred != '0) && !sctag_jbi_por_req;
    grant_rd = arb_pt && rd_elig && (!wr_elig || rr_rd);
    grant_wr = arb_pt && wr_elig && (!rd_elig || !rr_rd);
  end

  // FSM, beat counter and round-robin pointer.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      state <= IDLE;
      bcnt  <= '0;
      rr_rd <= 1'b1;
    end else begin
      if (arb_pt) begin
        bcnt <= '0;
        if (grant_rd)      state <= RD_XFER;
        else if (grant_wr) state <= WR_XFER;
        else               state <= IDLE;
        // Pointer only moves when both sources contended.
        if (rd_elig && wr_elig) rr_rd <= grant_wr;
      end else begin
        bcnt <= bcnt + BCNT_W'(1);
      end
    end
  end

  // Bus and source handshakes are decoded from the registered state.
  always_comb begin
    jbi_sctag_req     = '0;
    jbi_sctag_req_vld = 1'b0;
    rd_beat_rdy       = 1'b0;
    rd_beat_idx       = '0;
    wr_beat_rdy       = 1'b0;
    wr_beat_idx       = '0;
    case (state)
      RD_XFER: begin
        jbi_sctag_req     = rd_data;
        jbi_sctag_req_vld = (bcnt == '0);
        rd_beat_rdy       = 1'b1;
        rd_beat_idx       = bcnt;
      end
      WR_XFER: begin
        jbi_sctag_req     = wr_data;
        jbi_sctag_req_vld = (bcnt == '0);
        wr_beat_rdy       = 1'b1;
        wr_beat_idx       = bcnt;
      end
      default: ;
    endcase
  end

  jbi_cred_cnt #(.MAX(IQ_CREDITS), .W(IQ_CRED_W)) u_iq_cred (
    .clk   (rclk),
    .rst_n (arst_l),
    .take  (grant_rd | grant_wr),
    .deq   (sctag_jbi_iq_dequeue),
    .cnt   (iq_cred),
    .err   (iq_err)
  );

  jbi_cred_cnt #(.MAX(WIB_CREDITS), .W(WIB_CRED_W)) u_wib_cred (
    .clk   (rclk),
    .rst_n (arst_l),
    .take  (grant_wr),
    .deq   (sctag_jbi_wib_dequeue),
    .cnt   (wib_cred),
    .err   (wib_err)
  );

  assign cred_err = iq_err | wib_err;

endmodule

// File: tb/tb_jbi_sctag_req_sched.sv
module tb_jbi_sctag_req_sched;

  logic        rclk = 1'b0;
  logic        arst_l;
  logic        rd_req, wr_req;
  logic [31:0] rd_data, wr_data;
  logic        rd_beat_rdy, wr_beat_rdy;
  logic [4:0]  rd_beat_idx, wr_beat_idx;
  logic        iq_deq, wib_deq, por_req;
  logic [31:0] jbi_sctag_req;
  logic        jbi_sctag_req_vld;
  logic [4:0]  iq_cred;
  logic [2:0]  wib_cred;
  logic        cred_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 rclk = ~rclk;

  // Source models: beat data tagged with the source and beat index.
  assign rd_data = 32'hA000_0000 + {27'd0, rd_beat_idx};
  assign wr_data = 32'hB000_0000 + {27'd0, wr_beat_idx};

  jbi_sctag_req_sched dut (
    .rclk                  (rclk),
    .arst_l                (arst_l),
    .rd_req                (rd_req),
    .rd_data               (rd_data),
    .rd_beat_rdy           (rd_beat_rdy),
    .rd_beat_idx           (rd_beat_idx),
    .wr_req                (wr_req),
    .wr_data               (wr_data),
    .wr_beat_rdy           (wr_beat_rdy),
    .wr_beat_idx           (wr_beat_idx),
    .sctag_jbi_iq_dequeue  (iq_deq),
    .sctag_jbi_wib_dequeue (wib_deq),
    .sctag_jbi_por_req     (por_req),
    .jbi_sctag_req         (jbi_sctag_req),
    .jbi_sctag_req_vld     (jbi_sctag_req_vld),
    .iq_cred               (iq_cred),
    .wib_cred              (wib_cred),
    .cred_err              (cred_err)
  );

  task automatic step();
    @(posedge rclk);
    #2;
  endtask

  task automatic do_reset();
    arst_l  = 1'b0;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    iq_deq  = 1'b0;
    wib_deq = 1'b0;
    por_req = 1'b0;
    repeat (2) @(posedge rclk);
    #2 arst_l = 1'b1;
  endtask

  task automatic test_reset();
    arst_l  = 1'b0;
    rd_req  = 1'b1;
    wr_req  = 1'b1;
    iq_deq  = 1'b0;
    wib_deq = 1'b0;
    por_req = 1'b0;
    repeat (3) @(posedge rclk);
    #2;
    n_checks++;
    if (jbi_sctag_req !== 32'd0 || jbi_sctag_req_vld !== 1'b0) begin
      n_fail++; $display("FAIL reset_bus: req=%h vld=%b, want 0/0", jbi_sctag_req, jbi_sctag_req_vld);
    end
    n_checks++;
    if (rd_beat_rdy !== 1'b0 || wr_beat_rdy !== 1'b0 || rd_beat_idx !== 5'd0 || wr_beat_idx !== 5'd0) begin
      n_fail++; $display("FAIL reset_rdy: rd=%b/%0d wr=%b/%0d, want all 0", rd_beat_rdy, rd_beat_idx, wr_beat_rdy, wr_beat_idx);
    end
    n_checks++;
    if (iq_cred !== 5'd16 || wib_cred !== 3'd4 || cred_err !== 1'b0) begin
      n_fail++; $display("FAIL reset_cred: iq=%0d wib=%0d err=%b, want 16/4/0", iq_cred, wib_cred, cred_err);
    end
    do_reset();
  endtask

  task automatic test_single_read();
    do_reset();
    rd_req = 1'b1;
    step();
    n_checks++;
    if (jbi_sctag_req_vld !== 1'b1 || jbi_sctag_req !== 32'hA000_0000 || rd_beat_rdy !== 1'b1 || rd_beat_idx !== 5'd0) begin
      n_fail++; $display("FAIL rd_beat0: vld=%b req=%h rdy=%b idx=%0d, want 1/a0000000/1/0", jbi_sctag_req_vld, jbi_sctag_req, rd_beat_rdy, rd_beat_idx);
    end
    n_checks++;
    if (iq_cred !== 5'd15 || wib_cred !== 3'd4) begin
      n_fail++; $display("FAIL rd_cred: iq=%0d wib=%0d, want 15/4", iq_cred, wib_cred);
    end
    rd_req = 1'b0;
    step();
    n_checks++;
    if (jbi_sctag_req_vld !== 1'b0 || jbi_sctag_req !== 32'hA000_0001 || rd_beat_idx !== 5'd1 || wr_beat_rdy !== 1'b0) begin
      n_fail++; $display("FAIL rd_beat1: vld=%b req=%h idx=%0d wrdy=%b, want 0/a0000001/1/0", jbi_sctag_req_vld, jbi_sctag_req, rd_beat_idx, wr_beat_rdy);
    end
    step();
    n_checks++;
    if (jbi_sctag_req_vld !== 1'b0 || jbi_sctag_req !== 32'd0 || rd_beat_rdy !== 1'b0 || iq_cred !== 5'd15) begin
      n_fail++; $display("FAIL rd_idle: vld=%b req=%h rdy=%b iq=%0d, want 0/0/0/15", jbi_sctag_req_vld, jbi_sctag_req, rd_beat_rdy, iq_cred);
    end
  endtask

  // R,W alternate until WIB runs out, then reads until IQ runs out.
  task automatic test_back_to_back();
    logic        is_wr;
    int          nb;
    logic [31:0] exp;
    do_reset();
    rd_req = 1'b1;
    wr_req = 1'b1;
    for (int p = 0; p < 16; p++) begin
      is_wr = (p < 8) && (p % 2 == 1);
      nb    = is_wr ? 18 : 2;
      for (int b = 0; b < nb; b++) begin
        step();
        exp = (is_wr ? 32'hB000_0000 : 32'hA000_0000) + 32'(b);
        n_checks++;
        if (jbi_sctag_req !== exp || jbi_sctag_req_vld !== (b == 0) || rd_beat_rdy !== !is_wr || wr_beat_rdy !== is_wr) begin
          n_fail++; $display("FAIL b2b pkt%0d beat%0d: req=%h vld=%b rrdy=%b wrdy=%b, want %h/%b/%b/%b",
                             p, b, jbi_sctag_req, jbi_sctag_req_vld, rd_beat_rdy, wr_beat_rdy, exp, (b == 0), !is_wr, is_wr);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (jbi_sctag_req_vld !== 1'b0 || rd_beat_rdy !== 1'b0 || wr_beat_rdy !== 1'b0) begin
        n_fail++; $display("FAIL b2b_exhausted cyc%0d: vld=%b rrdy=%b wrdy=%b, want 0/0/0", i, jbi_sctag_req_vld, rd_beat_rdy, wr_beat_rdy);
      end
    end
    n_checks++;
    if (iq_cred !== 5'd0 || wib_cred !== 3'd0 || cred_err !== 1'b0) begin
      n_fail++; $display("FAIL b2b_cred: iq=%0d wib=%0d err=%b, want 0/0/0", iq_cred, wib_cred, cred_err);
    end
  endtask

  // Continues from the exhausted state left by test_back_to_back.
  task automatic test_credit_return();
    rd_req  = 1'b0;
    iq_deq  = 1'b1;
    wib_deq = 1'b1;
    step();
    iq_deq  = 1'b0;
    wib_deq = 1'b0;
    n_checks++;
    if (iq_cred !== 5'd1 || wib_cred !== 3'd1 || jbi_sctag_req_vld !== 1'b0) begin
      n_fail++; $display("FAIL cret_return: iq=%0d wib=%0d vld=%b, want 1/1/0", iq_cred, wib_cred, jbi_sctag_req_vld);
    end
    for (int b = 0; b < 18; b++) begin
      step();
      n_checks++;
      if (wr_beat_rdy !== 1'b1 || wr_beat_idx !== 5'(b) || jbi_sctag_req !== 32'hB000_0000 + 32'(b) || jbi_sctag_req_vld !== (b == 0)) begin
        n_fail++; $display("FAIL cret_wr beat%0d: wrdy=%b idx=%0d req=%h vld=%b", b, wr_beat_rdy, wr_beat_idx, jbi_sctag_req, jbi_sctag_req_vld);
      end
    end
    step();
    n_checks++;
    if (wr_beat_rdy !== 1'b0 || rd_beat_rdy !== 1'b0 || iq_cred !== 5'd0 || wib_cred !== 3'd0) begin
      n_fail++; $display("FAIL cret_idle: wrdy=%b rrdy=%b iq=%0d wib=%0d, want 0/0/0/0", wr_beat_rdy, rd_beat_rdy, iq_cred, wib_cred);
    end
    wr_req = 1'b0;
  endtask

  task automatic test_same_cycle();
    bit found = 1'b0;
    do_reset();
    rd_req = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (rd_beat_rdy === 1'b1 && rd_beat_idx === 5'd1 && iq_cred === 5'd5) begin
        found = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!found) begin
      n_fail++; $display("FAIL same_wait: never reached last read beat with iq=5 (iq=%0d)", iq_cred);
    end
    iq_deq = 1'b1;
    step();
    iq_deq = 1'b0;
    rd_req = 1'b0;
    n_checks++;
    if (iq_cred !== 5'd5 || jbi_sctag_req_vld !== 1'b1 || rd_beat_rdy !== 1'b1) begin
      n_fail++; $display("FAIL same_take_deq: iq=%0d vld=%b rrdy=%b, want 5/1/1", iq_cred, jbi_sctag_req_vld, rd_beat_rdy);
    end
    repeat (2) step();
    n_checks++;
    if (iq_cred !== 5'd5 || rd_beat_rdy !== 1'b0) begin
      n_fail++; $display("FAIL same_after: iq=%0d rrdy=%b, want 5/0", iq_cred, rd_beat_rdy);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    #1;
    n_checks++;
    if (cred_err !== 1'b0) begin
      n_fail++; $display("FAIL ovf_pre: err=%b, want 0", cred_err);
    end
    iq_deq = 1'b1;
    step();
    iq_deq = 1'b0;
    n_checks++;
    if (iq_cred !== 5'd16 || cred_err !== 1'b1) begin
      n_fail++; $display("FAIL ovf_iq: iq=%0d err=%b, want 16/1", iq_cred, cred_err);
    end
    wib_deq = 1'b1;
    step();
    wib_deq = 1'b0;
    n_checks++;
    if (wib_cred !== 3'd4) begin
      n_fail++; $display("FAIL ovf_wib: wib=%0d, want 4", wib_cred);
    end
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    repeat (4) step();
    n_checks++;
    if (cred_err !== 1'b1 || iq_cred !== 5'd15) begin
      n_fail++; $display("FAIL ovf_sticky: err=%b iq=%0d, want 1/15", cred_err, iq_cred);
    end
  endtask

  task automatic test_por();
    do_reset();
    wr_req = 1'b1;
    step();
    repeat (3) step();
    n_checks++;
    if (wr_beat_rdy !== 1'b1 || wr_beat_idx !== 5'd3) begin
      n_fail++; $display("FAIL por_beat3: wrdy=%b idx=%0d, want 1/3", wr_beat_rdy, wr_beat_idx);
    end
    por_req = 1'b1;
    for (int b = 4; b < 18; b++) begin
      step();
      n_checks++;
      if (wr_beat_rdy !== 1'b1 || wr_beat_idx !== 5'(b) || jbi_sctag_req !== 32'hB000_0000 + 32'(b)) begin
        n_fail++; $display("FAIL por_finish beat%0d: wrdy=%b idx=%0d req=%h", b, wr_beat_rdy, wr_beat_idx, jbi_sctag_req);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (jbi_sctag_req_vld !== 1'b0 || wr_beat_rdy !== 1'b0 || rd_beat_rdy !== 1'b0) begin
        n_fail++; $display("FAIL por_hold cyc%0d: vld=%b wrdy=%b rrdy=%b, want 0/0/0", i, jbi_sctag_req_vld, wr_beat_rdy, rd_beat_rdy);
      end
    end
    por_req = 1'b0;
    step();
    wr_req = 1'b0;
    n_checks++;
    if (jbi_sctag_req_vld !== 1'b1 || wr_beat_rdy !== 1'b1 || wib_cred !== 3'd2) begin
      n_fail++; $display("FAIL por_resume: vld=%b wrdy=%b wib=%0d, want 1/1/2", jbi_sctag_req_vld, wr_beat_rdy, wib_cred);
    end
    repeat (18) step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr_req = 1'b1;
    step();
    repeat (7) step();
    n_checks++;
    if (wr_beat_idx !== 5'd7 || wr_beat_rdy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_beat7: idx=%0d wrdy=%b, want 7/1", wr_beat_idx, wr_beat_rdy);
    end
    arst_l = 1'b0;
    #1;
    n_checks++;
    if (jbi_sctag_req !== 32'd0 || jbi_sctag_req_vld !== 1'b0 || wr_beat_rdy !== 1'b0 || wr_beat_idx !== 5'd0 || rd_beat_rdy !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_outs: req=%h vld=%b wrdy=%b widx=%0d rrdy=%b, want all 0",
                         jbi_sctag_req, jbi_sctag_req_vld, wr_beat_rdy, wr_beat_idx, rd_beat_rdy);
    end
    n_checks++;
    if (iq_cred !== 5'd16 || wib_cred !== 3'd4) begin
      n_fail++; $display("FAIL rstmid_cred: iq=%0d wib=%0d, want 16/4", iq_cred, wib_cred);
    end
    rd_req = 1'b1;
    wr_req = 1'b1;
    @(negedge rclk);
    arst_l = 1'b1;
    step();
    n_checks++;
    if (rd_beat_rdy !== 1'b1 || wr_beat_rdy !== 1'b0 || jbi_sctag_req !== 32'hA000_0000 || jbi_sctag_req_vld !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_rr: rrdy=%b wrdy=%b req=%h vld=%b, want 1/0/a0000000/1", rd_beat_rdy, wr_beat_rdy, jbi_sctag_req, jbi_sctag_req_vld);
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_read();
    test_back_to_back();
    test_credit_return();
    test_same_cycle();
    test_overflow();
    test_por();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
